// File: rtl/decode_pkg.sv
// Shared widths, types and constants for the decode writeback path.
package decode_pkg;

  localparam int NUM_SRC_DEF    = 3;
  localparam int REGS_PTR_W_DEF = 5;
  localparam int REG_SIZE_DEF   = 32;

  typedef logic [REGS_PTR_W_DEF-1:0] reg_ptr_t;
  typedef logic [REG_SIZE_DEF-1:0]   reg_data_t;

  // x0 is hardwired to zero; writes to it never reach the register file
  localparam reg_ptr_t ZERO_REG = '0;

endpackage

// File: rtl/decode_rr_arb.sv
// Generic round-robin arbiter: grants the first requester at or after rr_ptr,
// wrapping modulo NUM_SRC. Purely combinational; the pointer lives upstream.
module decode_rr_arb #(
  parameter int NUM_SRC = 3,
  parameter int PTR_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic               en,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_SRC-1:0] gnt,
  output logic [PTR_W-1:0]   gnt_idx
);

  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_sel;

  // Scan offsets from farthest to nearest so the nearest requester wins last
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_sum   = '0;
    w_sel   = '0;
    for (int k = NUM_SRC-1; k >= 0; k--) begin
      w_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(NUM_SRC)) w_sum = w_sum - (PTR_W+1)'(NUM_SRC);
      w_sel = w_sum[PTR_W-1:0];
      if (en && req[w_sel]) begin
        gnt        = '0;
        gnt[w_sel] = 1'b1;
        gnt_idx    = w_sel;
      end
    end
  end

endmodule

// File: rtl/decode_wb_arbiter.sv
// Round-robin share of the single register-file write port among NUM_SRC
// writeback sources, with registered output, x0 drop and a saturating
// contention counter. Optional decode bypass ports under DECODE_WB_FWD_EN.
module decode_wb_arbiter
  import decode_pkg::*;
#(
  parameter int NUM_SRC    = NUM_SRC_DEF,
  parameter int REGS_PTR_W = REGS_PTR_W_DEF,
  parameter int REG_SIZE   = REG_SIZE_DEF,
  parameter int CNT_W      = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 flush,
  input  logic [NUM_SRC-1:0]                   src_vld,
  output logic [NUM_SRC-1:0]                   src_rdy,
  input  logic [NUM_SRC-1:0][REGS_PTR_W-1:0]   src_wa,
  input  logic [NUM_SRC-1:0][REG_SIZE-1:0]     src_wd,
  output logic                                 rf_we,
  output logic [REGS_PTR_W-1:0]                rf_wa,
  output logic [REG_SIZE-1:0]                  rf_wd,
  output logic [CNT_W-1:0]                     cont_cnt
`ifdef DECODE_WB_FWD_EN
  ,
  input  logic [REGS_PTR_W-1:0]                rs1,
  input  logic [REGS_PTR_W-1:0]                rs2,
  output logic                                 fwd1_hit,
  output logic                                 fwd2_hit,
  output logic [REG_SIZE-1:0]                  fwd_wd
`endif
);

  localparam int PTR_W = $clog2(NUM_SRC);

  logic [PTR_W-1:0]      r_rr_ptr;
  logic                  r_rf_we;
  logic [REGS_PTR_W-1:0] r_rf_wa;
  logic [REG_SIZE-1:0]   r_rf_wd;
  logic [CNT_W-1:0]      r_cnt;

  logic [NUM_SRC-1:0]    w_gnt;
  logic [PTR_W-1:0]      w_gnt_idx;
  logic                  w_xfer;
  logic                  w_multi;
  logic [REGS_PTR_W-1:0] w_wa;
  logic [REG_SIZE-1:0]   w_wd;

  // Grants are suppressed during flush and while reset is held
  decode_rr_arb #(.NUM_SRC(NUM_SRC), .PTR_W(PTR_W)) u_arb (
    .req     (src_vld),
    .en      (!flush && rst_n),
    .rr_ptr  (r_rr_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign src_rdy = w_gnt;
  assign w_xfer  = |w_gnt;
  assign w_wa    = src_wa[w_gnt_idx];
  assign w_wd    = src_wd[w_gnt_idx];
  // Two or more requesters: clear lowest set bit and see if anything remains
  assign w_multi = |(src_vld & (src_vld - NUM_SRC'(1)));

  // Pointer moves just past the winner on each transfer, otherwise holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_rr_ptr <= '0;
    else if (w_xfer)
      r_rr_ptr <= (w_gnt_idx == PTR_W'(NUM_SRC-1)) ? '0 : w_gnt_idx + PTR_W'(1);
  end

  // Output stage: one-cycle registered write; x0 completes but never enables
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_we <= 1'b0;
      r_rf_wa <= '0;
      r_rf_wd <= '0;
    end else if (w_xfer) begin
      r_rf_we <= (w_wa != REGS_PTR_W'(ZERO_REG));
      r_rf_wa <= w_wa;
      r_rf_wd <= w_wd;
    end else begin
      r_rf_we <= 1'b0;
    end
  end

  // Contention counter, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (!flush && w_multi && (r_cnt != '1))
      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign rf_we    = r_rf_we;
  assign rf_wa    = r_rf_wa;
  assign rf_wd    = r_rf_wd;
  assign cont_cnt = r_cnt;

`ifdef DECODE_WB_FWD_EN
  // Bypass the write landing at the next edge; rf_we already excludes x0
  assign fwd1_hit = r_rf_we && (r_rf_wa == rs1);
  assign fwd2_hit = r_rf_we && (r_rf_wa == rs2);
  assign fwd_wd   = r_rf_wd;
`endif

endmodule

// File: tb/tb_decode_wb_arbiter.sv
// Directed + randomized bench for decode_wb_arbiter against a queue-free
// behavioural model of the round-robin writeback rules.
module tb_decode_wb_arbiter;

  localparam int N   = 3;
  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic               clk;
  logic               rst_n;
  logic               flush;
  logic [N-1:0]       src_vld;
  logic [N-1:0]       src_rdy;
  logic [N-1:0][AW-1:0] src_wa;
  logic [N-1:0][DW-1:0] src_wd;
  logic               rf_we;
  logic [AW-1:0]      rf_wa;
  logic [DW-1:0]      rf_wd;
  logic [CW-1:0]      cont_cnt;
  logic [AW-1:0]      rs1, rs2;
  logic               fwd1_hit, fwd2_hit;
  logic [DW-1:0]      fwd_wd;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int           m_ptr;
  int           m_cnt;
  logic         m_we;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;
  int           m_last_g;

  decode_wb_arbiter #(.NUM_SRC(N), .REGS_PTR_W(AW), .REG_SIZE(DW), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .src_vld  (src_vld),
    .src_rdy  (src_rdy),
    .src_wa   (src_wa),
    .src_wd   (src_wd),
    .rf_we    (rf_we),
    .rf_wa    (rf_wa),
    .rf_wd    (rf_wd),
    .cont_cnt (cont_cnt)
`ifdef DECODE_WB_FWD_EN
    ,
    .rs1      (rs1),
    .rs2      (rs2),
    .fwd1_hit (fwd1_hit),
    .fwd2_hit (fwd2_hit),
    .fwd_wd   (fwd_wd)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [N-1:0] v, input logic fl);
    if (fl) return -1;
    for (int k = 0; k < N; k++)
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_cnt = 0; m_we = 1'b0; m_wa = '0; m_wd = '0; m_last_g = -1;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".rf_we"}, 64'(rf_we), 64'(m_we));
    chk({tag, ".rf_wa"}, 64'(rf_wa), 64'(m_wa));
    chk({tag, ".rf_wd"}, 64'(rf_wd), 64'(m_wd));
    chk({tag, ".cnt"},   64'(cont_cnt), 64'(m_cnt));
  endtask

  // Called just after a posedge: drive, check grant, clock, check registers
  task automatic step(input string tag, input logic [N-1:0] v,
                      input logic [N-1:0][AW-1:0] wa,
                      input logic [N-1:0][DW-1:0] wd, input logic fl);
    int g;
    int ones;
    src_vld = v; src_wa = wa; src_wd = wd; flush = fl;
    rs1 = ($urandom_range(0, 1) == 1) ? m_wa : AW'($urandom);
    rs2 = AW'($urandom);
    #2;
    g = model_grant(v, fl);
    chk({tag, ".rdy"}, 64'(src_rdy), (g < 0) ? 64'd0 : (64'd1 << g));
`ifdef DECODE_WB_FWD_EN
    chk({tag, ".fwd1"}, 64'(fwd1_hit), 64'(m_we && (m_wa == rs1)));
    chk({tag, ".fwd2"}, 64'(fwd2_hit), 64'(m_we && (m_wa == rs2)));
    chk({tag, ".fwdwd"}, 64'(fwd_wd), 64'(m_wd));
`endif
    @(posedge clk);
    ones = $countones(v);
    if (!fl && ones >= 2 && m_cnt < MAX) m_cnt++;
    if (g >= 0) begin
      m_we  = (wa[g] != 0);
      m_wa  = wa[g];
      m_wd  = wd[g];
      m_ptr = (g + 1) % N;
    end else begin
      m_we = 1'b0;
    end
    m_last_g = g;
    #1;
    chk_regs(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; src_vld = '0; flush = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    chk_regs("reset");
    chk("reset.rdy", 64'(src_rdy), 64'd0);
    rst_n = 1'b1;
  endtask

  logic [N-1:0][AW-1:0] wa;
  logic [N-1:0][DW-1:0] wd;
  logic [N-1:0]         p_vld;

  initial begin
    rst_n = 1'b0; flush = 1'b0; src_vld = '0; src_wa = '0; src_wd = '0;
    rs1 = '0; rs2 = '0;
    model_reset();
    #1;
    chk_regs("por");
    do_reset();

    // single source
    wa = '0; wd = '0; wa[1] = 5'd5; wd[1] = 32'hDEAD_BEEF;
    step("single", 3'b010, wa, wd, 1'b0);
    chk("single.we_const", 64'(rf_we), 64'd1);
    chk("single.wd_const", 64'(rf_wd), 64'hDEAD_BEEF);

    // all three valid for 6 cycles from reset
    do_reset();
    wa[0] = 5'd1; wa[1] = 5'd2; wa[2] = 5'd3;
    wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2;
    for (int c = 0; c < 6; c++) begin
      step("all3", 3'b111, wa, wd, 1'b0);
      chk("all3.order", 64'(m_last_g), 64'(c % 3));
    end
    chk("all3.cnt6", 64'(cont_cnt), 64'd6);

    // wrap: grant to 1 then 101 -> 2, 0
    step("wrap.a", 3'b010, wa, wd, 1'b0);
    step("wrap.b", 3'b101, wa, wd, 1'b0);
    chk("wrap.b_src", 64'(rf_wa), 64'd3);
    step("wrap.c", 3'b101, wa, wd, 1'b0);
    chk("wrap.c_src", 64'(rf_wa), 64'd1);

    // x0 write
    wa[0] = 5'd0; wd[0] = 32'h1234;
    step("x0", 3'b001, wa, wd, 1'b0);
    chk("x0.we_const", 64'(rf_we), 64'd0);

    // flush for 2 cycles with a write still in the output register
    wa[0] = 5'd7;
    step("preflush", 3'b001, wa, wd, 1'b0);
    step("flush.a", 3'b111, wa, wd, 1'b1);
    step("flush.b", 3'b111, wa, wd, 1'b1);
    step("postflush", 3'b111, wa, wd, 1'b0);

    // reset mid-flight while rf_we=1
    chk("midrst.pre_we", 64'(rf_we), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.we", 64'(rf_we), 64'd0);
    chk("midrst.wa", 64'(rf_wa), 64'd0);
    chk("midrst.wd", 64'(rf_wd), 64'd0);
    chk("midrst.cnt", 64'(cont_cnt), 64'd0);
    chk("midrst.rdy", 64'(src_rdy), 64'd0);
    @(posedge clk); #1;
    model_reset();
    rst_n = 1'b1;
    step("postrst", 3'b111, wa, wd, 1'b0);
    chk("postrst.src0", 64'(rf_wa), 64'd7);

    // randomized: sources hold requests until served
    p_vld = '0;
    for (int it = 0; it < 400; it++) begin
      for (int s = 0; s < N; s++) begin
        if (!p_vld[s] && $urandom_range(0, 9) < 6) begin
          p_vld[s] = 1'b1;
          wa[s] = ($urandom_range(0, 5) == 0) ? 5'd0 : AW'($urandom);
          wd[s] = $urandom;
        end
      end
      step("rand", p_vld, wa, wd, ($urandom_range(0, 7) == 0));
      if (m_last_g >= 0) p_vld[m_last_g] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_wb_arbiter.md
Name: decode_wb_arbiter

Overview:
Shares the single register-file write port (we/wa/wd) between NUM_SRC writeback sources, such as the ALU, load unit and CSR unit. Each source uses a valid/ready handshake. Arbitration is round-robin, with one winner per cycle. The winning write is registered and driven to the register file one cycle later. Writes to x0 are accepted and dropped, and a saturating contention counter is provided for performance debug.

Parameters:
NUM_SRC, 3, number of writeback requesters (2..8)
REGS_PTR_W, 5, register address width
REG_SIZE, 32, register data width
CNT_W, 16, contention counter width

Ports:
clk  input  1  clock
rst_n  input  1  reset; asynchronous, active-low
flush  input  1  pipeline flush; blocks grants this cycle
src_vld  input  NUM_SRC  per-source write request
src_rdy  output  NUM_SRC  per-source grant; one-hot or zero
src_wa  input  NUM_SRC*REGS_PTR_W  per-source destination register
src_wd  input  NUM_SRC*REG_SIZE  per-source write data
rf_we  output  1  register-file write enable, registered
rf_wa  output  REGS_PTR_W  register-file write address, registered
rf_wd  output  REG_SIZE  register-file write data, registered
cont_cnt  output  CNT_W  saturating count of contention cycles

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rf_we=0, rf_wa=0, rf_wd=0, cont_cnt=0.
  - Round-robin pointer rr_ptr=0.
  - src_rdy=0 while reset is asserted.
- Grant (combinational, same cycle):
  - If flush=0 and any src_vld, grant the first valid source scanning rr_ptr, rr_ptr+1, … with wrap modulo NUM_SRC.
  - src_rdy is high only for the winner. It depends only on src_vld, rr_ptr and flush, never on src_wa/src_wd.
- Transfer: occurs when src_vld[i] & src_rdy[i]. The source must hold vld, wa and wd stable until the transfer; the arbiter never takes back a grant within a cycle.
- Pointer update:
  - On a transfer from source i, rr_ptr <= (i+1) mod NUM_SRC. For i=NUM_SRC-1 it wraps to 0.
  - With no transfer, rr_ptr holds.
- Output stage:
  - On a transfer: rf_we <= (winner wa != 0), rf_wa <= wa, rf_wd <= wd. Latency is 1 cycle from handshake to rf_we.
  - Writes to x0 complete the handshake but produce rf_we=0. rf_wa/rf_wd are still updated.
  - With no transfer: rf_we <= 0, and rf_wa/rf_wd hold.
- flush=1:
  - All src_rdy=0 that cycle; rf_we <= 0 next cycle; rr_ptr holds.
  - A write already in the output register (rf_we=1 this cycle) still commits; flush does not cancel it.
- Contention counter:
  - cont_cnt increments when flush=0 and two or more src_vld bits are high.
  - Saturates at 2^CNT_W-1; no wrap.
- Sources stay independent:
  - A source that remains valid is served within NUM_SRC cycles, provided flush is low.
  - Same-address writes from different sources commit in grant order; the later one wins in the register file.
- Reset mid-operation: in-flight registered writes are discarded (rf_we=0 immediately). No source sees a transfer in that cycle.

Optional Feature:
Macro DECODE_WB_FWD_EN.
- When defined, add these ports:
  - rs1, rs2: inputs, REGS_PTR_W each.
  - fwd1_hit, fwd2_hit: outputs, 1 each.
  - fwd_wd: output, REG_SIZE.
- fwdN_hit = rf_we & (rf_wa == rsN), combinational. fwd_wd = rf_wd.
- This lets decode bypass the write that lands at the next edge.
- rf_we=0 for x0, so x0 never hits.
- When not defined, these ports and their logic do not exist. Behaviour is otherwise identical.

Decomposition:
- Package decode_pkg holds:
  - Defaults for REGS_PTR_W, REG_SIZE and NUM_SRC.
  - Typedef reg_ptr_t and typedef reg_data_t.
  - Constant ZERO_REG = '0.
- Sub-module decode_rr_arb: a generic NUM_SRC round-robin arbiter.
  - Inputs: req, en, rr_ptr.
  - Outputs: one-hot gnt, gnt_idx.
  - The pointer register, output stage and counter stay in the top module.

Test Plan:
- Single source: src_vld=3'b010, wa=5, wd=32'hDEAD_BEEF → src_rdy=3'b010 same cycle. Next cycle rf_we=1, rf_wa=5, rf_wd=32'hDEAD_BEEF.
- All three valid for 6 cycles from reset → grants in order 0,1,2,0,1,2. cont_cnt=6. rf_we=1 on cycles 1–6.
- Wrap: rr_ptr=2 (after a grant to source 1), src_vld=3'b101 → source 2 granted, then source 0. rr_ptr wraps 2→0→1.
- x0 write: source 0 wa=0, wd=32'h1234 → src_rdy[0]=1 and next cycle rf_we=0. With DECODE_WB_FWD_EN and rs1=0: fwd1_hit=0.
- Flush: src_vld=3'b111 with flush=1 for 2 cycles → src_rdy=0, rf_we=0, rr_ptr and cont_cnt unchanged. After flush drops, the grant goes to the pre-flush rr_ptr.
- Reset mid-flight: assert rst_n=0 asynchronously while rf_we=1 → rf_we, rf_wa, rf_wd, cont_cnt read 0 before the next clk edge. First grant after release goes to source 0.
